// File: rtl/serial_word_packer.sv
// serial_word_packer: LSB-first serial-to-parallel packer with a one-word hold register and sticky overflow.
// Define PARITY_CHECK_EN to require an even-parity bit after each word.
module serial_word_packer #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          frame_start,
  output logic [DW-1:0] word,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          busy,
  output logic          overflow,
  output logic          parity_err
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  state_t state, fs_state, n_state;
  logic [DW-1:0] sr, n_sr, cand;
  logic [CW-1:0] cnt, fs_cnt, n_cnt;
  logic acc, last, done, n_perr;
  // frame_start clears the counter and FSM before the bit of the same cycle is considered
  always_comb begin
    fs_state = frame_start ? IDLE : state;
    fs_cnt   = frame_start ? '0 : cnt;
    acc      = bit_valid && fs_state != PAR;
    last     = fs_cnt == CW'(DW - 1);
    n_sr     = acc ? {bit_in, sr[DW-1:1]} : sr;
    n_cnt    = acc ? (last ? '0 : fs_cnt + 1'b1) : fs_cnt;
`ifdef PARITY_CHECK_EN
    n_state  = acc ? (last ? PAR : SHIFT) : (bit_valid && fs_state == PAR) ? IDLE : fs_state;
    done     = bit_valid && fs_state == PAR;
    cand     = sr;
    n_perr   = ^sr ^ bit_in;
`else
    n_state  = acc ? (last ? IDLE : SHIFT) : fs_state;
    done     = acc && last;
    cand     = n_sr;
    n_perr   = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      sr         <= '0;
      cnt        <= '0;
      state      <= IDLE;
      word       <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sr    <= n_sr;
      cnt   <= n_cnt;
      state <= n_state;
      busy  <= n_state != IDLE;
      if (done && (!word_valid || word_ready)) begin
        word       <= cand;
        word_valid <= 1'b1;
        parity_err <= n_perr;
      end else if (done) overflow <= 1'b1;
      else if (word_ready) word_valid <= 1'b0;
    end
  end
endmodule
